// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // 2-of-3 majority used to vote the three mid-bit samples.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit timer and 3-sample majority voter for the oversampled RX line.
// edge_cnt walks 0..OVS-1 across one bit; the three samples sit around the
// bit centre and bit_done marks the last tick of the bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OVS = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic run,
  input  logic rx,
  output logic bit_val,
  output logic bit_done
);

  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] S0   = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] S1   = CW'(OVS / 2);
  localparam logic [CW-1:0] S2   = CW'(OVS / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(OVS - 1);

  logic [CW-1:0] edge_cnt;
  logic          smp0, smp1, smp2;
  logic          smp2_eff;

  // Tick counter within the current bit; restarted on every start detection.
  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      edge_cnt <= '0;
    end else if (run) begin
      edge_cnt <= (edge_cnt == LAST) ? '0 : edge_cnt + 1'b1;
    end
  end

  // Capture the three mid-bit samples.
  always_ff @(posedge CLK) begin
    if (RST) begin
      smp0 <= 1'b1;
      smp1 <= 1'b1;
      smp2 <= 1'b1;
    end else if (run) begin
      if (edge_cnt == S0) smp0 <= rx;
      if (edge_cnt == S1) smp1 <= rx;
      if (edge_cnt == S2) smp2 <= rx;
    end
  end

  // With OVS=4 the third sample lands on the last tick, so use the live line.
  always_comb begin
    smp2_eff = (edge_cnt == S2) ? rx : smp2;
    bit_val  = majority3(smp0, smp1, smp2_eff);
    bit_done = run && (edge_cnt == LAST);
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronizer, frame FSM, shift register, parity check and
// registered one-cycle result pulses (DATA_VLD / PAR_ERR / STP_ERR).
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVS        = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VLD,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output rx_state_t             DBG_STATE
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  rx_state_t             state, state_nxt;
  logic                  rx_s1, rx_s;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en_l, par_typ_l, par_bad;
  logic                  bit_val, bit_done;
  logic                  start_det;
  logic                  vld_nxt, perr_nxt, serr_nxt;
  logic                  exp_par;

  assign DBG_STATE = state;
  assign exp_par   = (par_typ_l == PAR_ODD) ? ~^shift : ^shift;

  uart_rx_sampler #(.OVS(OVS)) u_sampler (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (start_det),
    .run      (state != IDLE),
    .rx       (rx_s),
    .bit_val  (bit_val),
    .bit_done (bit_done)
  );

  // Two-flop synchronizer for the asynchronous serial line (idles high).
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_s1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_s1 <= RX_IN;
      rx_s  <= rx_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and frame resolution. The STOP exit checks the line itself so
  // a start bit arriving with zero idle gap is picked up on the exit cycle,
  // keeping back-to-back frames exactly one frame length apart.
  always_comb begin
    state_nxt = state;
    start_det = 1'b0;
    vld_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    serr_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (bit_done) state_nxt = bit_val ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && (bit_cnt == LAST_BIT)) state_nxt = par_en_l ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) begin
          serr_nxt = !bit_val;
          perr_nxt = par_bad;
          vld_nxt  = bit_val && !par_bad;
          if (!rx_s) begin
            state_nxt = START;
            start_det = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: bit counter, LSB-first shift register, parity tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt   <= '0;
      shift     <= '0;
      par_en_l  <= 1'b0;
      par_typ_l <= 1'b0;
      par_bad   <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt   <= '0;
        par_bad   <= 1'b0;
        par_en_l  <= PAR_EN;
        par_typ_l <= PAR_TYP;
      end
      if (state == DATA && bit_done) begin
        shift   <= {bit_val, shift[DATA_WIDTH-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == PARITY && bit_done) par_bad <= (bit_val != exp_par);
    end
  end

  // Registered result pulses; P_DATA only moves on a clean frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA   <= '0;
      DATA_VLD <= 1'b0;
      PAR_ERR  <= 1'b0;
      STP_ERR  <= 1'b0;
    end else begin
      DATA_VLD <= vld_nxt;
      PAR_ERR  <= perr_nxt;
      STP_ERR  <= serr_nxt;
      if (vld_nxt) P_DATA <= shift;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx (OVS=8, DATA_WIDTH=8).
module tb_uart_rx;
  import uart_pkg::*;

  localparam int W   = 8;
  localparam int OVS = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         RX_IN;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic [W-1:0] P_DATA;
  logic         DATA_VLD;
  logic         PAR_ERR;
  logic         STP_ERR;
  rx_state_t    DBG_STATE;

  uart_rx #(.DATA_WIDTH(W), .OVS(OVS)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VLD  (DATA_VLD),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .DBG_STATE (DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  int n_vld = 0, n_perr = 0, n_serr = 0;
  int vld_cyc_q[$];
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  // Monitor: counts pulses, logs DATA_VLD cycles, checks data against exp_q.
  always @(negedge CLK) begin
    if (DATA_VLD === 1'b1) begin
      n_vld++;
      vld_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("unexpected_vld", 1, 0);
      else                   check("sb_data", int'(P_DATA), int'(exp_q.pop_front()));
    end
    if (PAR_ERR === 1'b1) n_perr++;
    if (STP_ERR === 1'b1) n_serr++;
  end

  // ---------------- driver tasks ----------------
  // Drives one frame, OVS ticks per bit. flip_bit/flip_pos invert a single
  // tick inside one frame bit (flip_bit < 0 disables). fall_cyc returns the
  // cycle count of the first posedge that sees the start bit.
  task automatic send_frame(input logic [W-1:0] data, input logic pe, input logic pbit,
                            input logic stop, input int flip_bit, input int flip_pos,
                            output int fall_cyc);
    logic bits[W+3];
    int   nb;
    bits[0] = 1'b0;
    for (int i = 0; i < W; i++) bits[i+1] = data[i];
    nb = W + 1;
    if (pe) begin
      bits[nb] = pbit;
      nb++;
    end
    bits[nb] = stop;
    nb++;
    fall_cyc = 0;
    for (int b = 0; b < nb; b++) begin
      for (int t = 0; t < OVS; t++) begin
        @(posedge CLK);
        #1;
        if (b == 0 && t == 0) fall_cyc = cyc + 1;
        RX_IN = bits[b] ^ ((b == flip_bit) && (t == flip_pos));
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge CLK);
    #1;
    RX_IN = 1'b1;
    repeat (n - 1) @(posedge CLK);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] data;
    logic         pe, pt, pbit, stop;
    logic         exp_vld, exp_perr, exp_serr;
    logic [W-1:0] exp_pdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int fc, v0, p0, s0;

    vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h55};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[2] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
    vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};
    vecs[5] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01};
    vecs[6] = '{8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3};
    vecs[7] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hC3};

    RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_pdata", int'(P_DATA), 0);
    check("rst_flags", int'({DATA_VLD, PAR_ERR, STP_ERR}), 0);
    check("rst_state", int'(DBG_STATE), int'(IDLE));

    // Table-driven frames
    for (int i = 0; i < 8; i++) begin
      v0 = n_vld; p0 = n_perr; s0 = n_serr;
      vld_cyc_q.delete();
      PAR_EN  = vecs[i].pe;
      PAR_TYP = vecs[i].pt;
      if (vecs[i].exp_vld) exp_q.push_back(vecs[i].data);
      send_frame(vecs[i].data, vecs[i].pe, vecs[i].pbit, vecs[i].stop, -1, 0, fc);
      idle(16);
      @(negedge CLK);
      check($sformatf("v%0d_vld", i), n_vld - v0, int'(vecs[i].exp_vld));
      check($sformatf("v%0d_perr", i), n_perr - p0, int'(vecs[i].exp_perr));
      check($sformatf("v%0d_serr", i), n_serr - s0, int'(vecs[i].exp_serr));
      check($sformatf("v%0d_pdata", i), int'(P_DATA), int'(vecs[i].exp_pdata));
      check($sformatf("v%0d_state", i), int'(DBG_STATE), int'(IDLE));
      if (i == 0) begin
        if (vld_cyc_q.size() != 1) check("latency_pulse", vld_cyc_q.size(), 1);
        else                       check("latency", vld_cyc_q[0] - fc, 82);
      end
    end

    // Short low glitch: start bit votes high, back to IDLE, no pulses
    PAR_EN = 1'b0;
    v0 = n_vld; p0 = n_perr; s0 = n_serr;
    @(posedge CLK); #1 RX_IN = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RX_IN = 1'b1;
    idle(24);
    @(negedge CLK);
    check("glitch_pulses", (n_vld - v0) + (n_perr - p0) + (n_serr - s0), 0);
    check("glitch_state", int'(DBG_STATE), int'(IDLE));

    // Single-tick flip in the middle of data bit 2 (frame bit 3)
    v0 = n_vld;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 3, OVS / 2, fc);
    idle(16);
    @(negedge CLK);
    check("flip_vld", n_vld - v0, 1);
    check("flip_pdata", int'(P_DATA), 'h5A);

    // Reset during data bit 3 of 0xFF
    v0 = n_vld; p0 = n_perr; s0 = n_serr;
    @(posedge CLK); #1 RX_IN = 1'b0;
    repeat (8) @(posedge CLK);
    #1 RX_IN = 1'b1;
    repeat (28) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("midrst_pdata", int'(P_DATA), 0);
    check("midrst_flags", int'({DATA_VLD, PAR_ERR, STP_ERR}), 0);
    check("midrst_state", int'(DBG_STATE), int'(IDLE));
    idle(80);
    check("midrst_pulses", (n_vld - v0) + (n_perr - p0) + (n_serr - s0), 0);
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1, -1, 0, fc);
    idle(16);
    @(negedge CLK);
    check("after_rst_vld", n_vld - v0, 1);
    check("after_rst_pdata", int'(P_DATA), 'h0F);

    // Back-to-back frames with no idle gap
    v0 = n_vld;
    vld_cyc_q.delete();
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_frame(8'h12, 1'b0, 1'b0, 1'b1, -1, 0, fc);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1, 0, fc);
    idle(16);
    @(negedge CLK);
    check("b2b_vld", n_vld - v0, 2);
    if (vld_cyc_q.size() != 2) check("b2b_pulses", vld_cyc_q.size(), 2);
    else                       check("b2b_spacing", vld_cyc_q[1] - vld_cyc_q[0], 80);
    check("b2b_pdata", int'(P_DATA), 'h34);

    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
